// File: rtl/power_key_descrambler.sv
// power_key_descrambler
//   Receive-side partner of the per-bit key-masking encoder
//   (enc = d ^ ((a^b) & (a^c))). It regenerates the key from a local 16-bit
//   LFSR kept in lockstep with the transmitter, unmasks each accepted bit and
//   deserializes LSB-first into WIDTH-bit words.
//
//   Optional feature macro: POWER_DESCR_PARITY_EN
//     defined   : each link word is WIDTH data bits plus one even-parity bit;
//                 out_perr flags a parity mismatch for the current out_word.
//     undefined : words are WIDTH bits and out_perr is tied to 0.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   seed_load/val     one-cycle pulse loads a new LFSR seed and resynchronises
//   in_valid/ready    serial encoded-bit handshake, in_bit carries the bit
//   out_valid/ready   word handshake, out_word bit 0 = first bit received
//   out_perr          parity error flag, valid with out_valid
module power_key_descrambler #(
  parameter int unsigned WIDTH        = 8,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [15:0]      seed_val,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_word,
  input  logic             out_ready,
  output logic             out_perr
);

`ifdef POWER_DESCR_PARITY_EN
  localparam int unsigned WordLen = WIDTH + 1;
`else
  localparam int unsigned WordLen = WIDTH;
`endif
  localparam int unsigned CntW = $clog2(WordLen);
  localparam logic [CntW-1:0] LastCnt = CntW'(WordLen - 1);
  // An all-zero LFSR would lock up, so zero seeds are replaced by 1.
  localparam logic [15:0] ResetSeed = (DEFAULT_SEED == 16'h0000) ? 16'h0001 : DEFAULT_SEED;

  typedef enum logic [0:0] {StRun, StResync} state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  state_e          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_word_q, out_word_d;
  logic             out_perr_q, out_perr_d;

  logic             key;
  logic             dec_bit;
  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] word_asm;

  // Key comes from the pre-advance LFSR state.
  assign key      = (lfsr_q[0] ^ lfsr_q[5]) & (lfsr_q[0] ^ lfsr_q[11]);
  assign dec_bit  = in_bit ^ key;
  assign last_bit = (bit_cnt_q == LastCnt);
  // Stall only the word-completing bit while an unaccepted word is pending.
  assign in_ready = (state_q == StRun) & ~seed_load & ~(last_bit & out_valid_q & ~out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    word_asm = shift_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (bit_cnt_q == CntW'(i)) word_asm[i] = dec_bit;
    end
  end

  always_comb begin
    state_d     = StRun;
    lfsr_d      = lfsr_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_perr_d  = out_perr_q;

    if (seed_load) begin
      state_d   = StResync;
      lfsr_d    = (seed_val == 16'h0000) ? 16'h0001 : seed_val;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (accept) begin
      lfsr_d = lfsr_next(lfsr_q);
      if (last_bit) begin
        bit_cnt_d = '0;
        shift_d   = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        shift_d   = word_asm;
      end
    end

    // A completing word can only be accepted when the output slot is free or
    // being drained this cycle, so loading overrides the clear.
    if (accept && last_bit) begin
      out_valid_d = 1'b1;
      out_word_d  = word_asm;
`ifdef POWER_DESCR_PARITY_EN
      // Parity bit is the last one on the link and never lands in shift_q.
      out_perr_d  = (^shift_q) ^ dec_bit;
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      lfsr_q      <= ResetSeed;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_perr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_perr_q  <= out_perr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_perr  = out_perr_q;

endmodule

// File: tb/tb_power_key_descrambler.sv
// Directed bench for power_key_descrambler (WIDTH=8, DEFAULT_SEED=16'hACE1).
module tb_power_key_descrambler;

`ifdef POWER_DESCR_PARITY_EN
  localparam int WL = 9;
  localparam logic PAR = 1'b1;
`else
  localparam int WL = 8;
  localparam logic PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_load;
  logic [15:0] seed_val;
  logic        in_valid;
  logic        in_bit;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_word;
  logic        out_ready;
  logic        out_perr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] m_lfsr;

  power_key_descrambler #(
    .WIDTH        (8),
    .DEFAULT_SEED (16'hACE1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed_val  (seed_val),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_word  (out_word),
    .out_ready (out_ready),
    .out_perr  (out_perr)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic key_of(input logic [15:0] s);
    return (s[0] ^ s[5]) & (s[0] ^ s[11]);
  endfunction

  // Called at a negedge; drives one raw link bit and returns at the next negedge.
  task automatic send_enc(input logic e);
    in_valid = 1'b1;
    in_bit   = e;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL in_ready_bit: got %b want 1", in_ready);
    end
    @(posedge clk);
    m_lfsr = step(m_lfsr);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] data, input logic flip);
    for (int i = 0; i < 8; i++) send_enc(data[i] ^ key_of(m_lfsr));
    if (PAR) send_enc((^data) ^ flip ^ key_of(m_lfsr));
  endtask

  task automatic test_reset;
    rst_n = 1'b0; seed_load = 1'b0; seed_val = 16'h0; in_valid = 1'b0; in_bit = 1'b0;
    out_ready = 1'b1;
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || out_word !== 8'h00 || out_perr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b w=%h p=%b want 0 00 0", out_valid, out_word, out_perr);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_lfsr = 16'hACE1;
    send_word(8'h3C, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 8'h3C) begin
      n_fail++;
      $display("FAIL reset_seed_word: got v=%b w=%h want 1 3c", out_valid, out_word);
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Seed 1 keys are 1,0,0,0,0,0,0,0,0 for the first nine bits, so raw link
  // 8'hB4 (parity bit raw 1) decodes to 8'hB5 with correct parity.
  task automatic send_seed_one_vector;
    logic [7:0] raw;
    raw = 8'hB4;
    for (int i = 0; i < 8; i++) send_enc(raw[i]);
    if (PAR) send_enc(1'b1);
  endtask

  task automatic test_seed_one;
    seed_load = 1'b1; seed_val = 16'h0001;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL seed_load_in_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    seed_load = 1'b0;
    @(negedge clk);
    m_lfsr = 16'h0001;
    send_seed_one_vector();
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 8'hB5 || out_perr !== 1'b0) begin
      n_fail++;
      $display("FAIL seed_one_word: got v=%b w=%h p=%b want 1 b5 0", out_valid, out_word, out_perr);
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [7:0] words [4];
    words = '{8'h12, 8'hEF, 8'h00, 8'hFF};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_word(words[k], 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || out_word !== words[k] || out_perr !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_word%0d: got v=%b w=%h p=%b want 1 %h 0", k, out_valid, out_word,
                 out_perr, words[k]);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure;
    logic [8:0] wb;
    out_ready = 1'b0;
    send_word(8'h5A, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 8'h5A) begin
      n_fail++;
      $display("FAIL bp_word1: got v=%b w=%h want 1 5a", out_valid, out_word);
    end
    wb = {^8'hC3, 8'hC3};
    for (int i = 0; i < WL - 1; i++) send_enc(wb[i] ^ key_of(m_lfsr));
    in_bit = wb[WL-1] ^ key_of(m_lfsr);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_stall: got in_ready=%b want 0", in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_word !== 8'h5A) begin
      n_fail++;
      $display("FAIL bp_hold: got r=%b v=%b w=%h want 0 1 5a", in_ready, out_valid, out_word);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got in_ready=%b want 1", in_ready);
    end
    @(posedge clk);
    m_lfsr = step(m_lfsr);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 8'hC3) begin
      n_fail++;
      $display("FAIL bp_word2: got v=%b w=%h want 1 c3", out_valid, out_word);
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_resync_zero;
    out_ready = 1'b1;
    send_enc(1'b1);
    send_enc(1'b0);
    send_enc(1'b1);
    seed_load = 1'b1; seed_val = 16'h0000; in_valid = 1'b1; in_bit = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL resync_load_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    seed_load = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL resync_state_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    m_lfsr = 16'h0001;
    send_seed_one_vector();
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 8'hB5 || out_perr !== 1'b0) begin
      n_fail++;
      $display("FAIL resync_word: got v=%b w=%h p=%b want 1 b5 0", out_valid, out_word, out_perr);
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    send_word(8'h96, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 8'h96) begin
      n_fail++;
      $display("FAIL areset_pre: got v=%b w=%h want 1 96", out_valid, out_word);
    end
    send_enc(1'b1);
    send_enc(1'b1);
    send_enc(1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_word !== 8'h00 || out_perr !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_clear: got v=%b w=%h p=%b want 0 00 0", out_valid, out_word, out_perr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    m_lfsr = 16'hACE1;
    send_word(8'h69, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 8'h69) begin
      n_fail++;
      $display("FAIL areset_redecode: got v=%b w=%h want 1 69", out_valid, out_word);
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_parity;
    out_ready = 1'b1;
    send_word(8'hA5, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 8'hA5 || out_perr !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_good: got v=%b w=%h p=%b want 1 a5 0", out_valid, out_word, out_perr);
    end
    send_word(8'hA5, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_word !== 8'hA5 || out_perr !== PAR) begin
      n_fail++;
      $display("FAIL parity_flip: got v=%b w=%h p=%b want 1 a5 %b", out_valid, out_word, out_perr,
               PAR);
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_seed_one();
    test_back_to_back();
    test_backpressure();
    test_resync_zero();
    test_async_reset();
    test_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/power_key_descrambler.md
Name: power_key_descrambler

Overview:
- Receive-side partner of the team's per-bit key-masking encoder, which computes `enc = d ^ ((a^b) & (a^c))`.
- Accepts a serial stream of encoded bits over a valid/ready handshake and regenerates the key bits a/b/c from a local LFSR kept in lockstep with the transmitter.
- Unmasks each bit with `d = enc ^ key`, deserializes the bits LSB-first, and presents WIDTH-bit words on a valid/ready output port.
- Sits between the serial link front-end and the word-level consumer in the power sub-circuit test harness.

Parameters:
- WIDTH, 8, decoded output word width in bits (2..32).
- DEFAULT_SEED, 16'hACE1, LFSR value loaded at reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seed_load  in  1  one-cycle pulse: load seed_val and resynchronise.
- seed_val  in  16  LFSR seed sampled when seed_load=1.
- in_valid  in  1  encoded bit present.
- in_bit  in  1  encoded bit.
- in_ready  out  1  decoder can accept in_bit this cycle.
- out_valid  out  1  decoded word available.
- out_word  out  WIDTH  decoded word; bit 0 = first bit received.
- out_ready  in  1  consumer accepts out_word.
- out_perr  out  1  parity error flag for the current out_word (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - lfsr=DEFAULT_SEED; if DEFAULT_SEED is 0, use 16'h0001.
  - bit_cnt=0, shift register=0.
  - out_valid=0, out_word=0, out_perr=0.
  - State=RUN.
  - A reset in the middle of a word discards the partial word and any pending output.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Next state is {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- Key: computed from the current (pre-advance) LFSR state.
  - a=lfsr[0], b=lfsr[5], c=lfsr[11].
  - key=(a^b)&(a^c).
- Bit accept (in_valid & in_ready):
  - d = in_bit ^ key.
  - d is written to shift position bit_cnt.
  - The LFSR advances one step and bit_cnt increments.
  - The LFSR never advances without an accepted bit.
- Word complete (the accepted bit lands at bit_cnt = WIDTH-1, no parity):
  - Next cycle: out_word = the assembled word, out_valid=1.
  - bit_cnt wraps to 0.
  - Latency: 1 cycle from the last accepted bit to out_valid.
- Output handshake:
  - out_valid holds, and out_word is stable, until out_valid & out_ready.
  - On that handshake out_valid clears, unless a new word completes in the same cycle; in that case the new word loads and out_valid stays 1.
- in_ready:
  - in_ready=0 only when the next accepted bit would complete a word AND out_valid=1 AND out_ready=0.
  - Otherwise in_ready=1; accepting partial bits while an output word is pending is allowed.
  - in_ready is combinational from out_ready.
- States: RUN, RESYNC.
  - seed_load=1 (any state) → RESYNC: lfsr=seed_val (0 replaced by 16'h0001), bit_cnt=0, partial word dropped.
  - A pending out_valid word is retained.
  - RESYNC lasts 1 cycle with in_ready=0, then → RUN.
  - seed_load coincident with a bit accept: seed_load wins and the bit is dropped. Since in_ready is forced 0 in that cycle, no handshake occurs.
- seed_load asserted on consecutive cycles: stays in RESYNC, reloads each cycle.

Optional Feature:
- Macro: POWER_DESCR_PARITY_EN.
- Defined:
  - Each word on the link is WIDTH data bits followed by one parity bit (word length WIDTH+1).
  - The parity bit is also key-unmasked and advances the LFSR.
  - The word completes after the parity bit.
  - out_perr = 1 if (XOR of decoded data bits) ≠ decoded parity bit (even parity). It is valid with out_valid and updates only when out_word loads.
- Undefined:
  - Words are WIDTH bits with no parity bit.
  - out_perr is tied to 0.

Test Plan:
- Reset, seed_load with seed_val=16'h0001, send encoded bit 0 → first decoded bit=1 (key: a=1, b=0, c=0 gives key=1). Encode 8 bits with a bench reference model → out_word equals the original data one cycle after the 8th bit.
- Stream 4 words back-to-back with out_ready=1 → 4 consecutive out_valid words, no in_ready drop, all match the model.
- Hold out_ready=0 after word 1, keep in_valid=1 → 7 further bits accepted, then in_ready=0 on the 8th. Release out_ready → word 1 handshakes, word 2 loads the same cycle, out_valid stays 1.
- Assert seed_load with seed_val=16'h0000 after 3 bits → partial word dropped, lfsr=16'h0001, in_ready=0 for 1 cycle. The next 8 bits decode as in the first scenario.
- Drop rst_n mid-word with out_valid=1 → out_valid=0, out_word=0, lfsr=16'hACE1 immediately (async). Redecode from DEFAULT_SEED matches the model.
- With POWER_DESCR_PARITY_EN defined: send data 8'hA5 with correct parity, then 8'hA5 with the parity bit flipped → out_perr=0, then out_perr=1. Undefined: out_perr stays 0 throughout.
